// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_stage_pkg;

    // Core-wide bubble markers that decode already recognises. REGPC_NOP is
    // deliberately misaligned, so it can never be a real fetch PC.
    localparam logic [31:0] INST_NOP  = 32'h0000_0013;
    localparam logic [31:0] REGPC_NOP = 32'hFFFF_FFFF;

    // One prefetch buffer entry: the PC a word was fetched from, plus the word.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // Redirect targets carry junk in the low bits; fetch is always word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_fifo.sv
// Prefetch buffer: synchronous FIFO with push/pop/flush and an occupancy count.
// Flush wins over a push in the same cycle. Pushing when full and popping when
// empty are ignored.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [WIDTH-1:0]       head_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty     = (count_q == '0);
    assign do_push   = push && (count_q != DEPTH_CNT);
    assign do_pop    = pop && !empty;
    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

    // Next-state for storage, pointers and count.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        end
    end

    // FIFO state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues in-order word requests under a
// credit limit, buffers returned words and hands one {inst, pc} per cycle to
// decode. A redirect flushes the buffer and drops every response still owed.
import fetch_stage_pkg::*;

module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        branch_hazard,
    input  logic [31:0] branch_target,
    input  logic        stall_flg,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_inst,
    output logic [31:0] inst,
    output logic [31:0] reg_pc
);

    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_LIM = (CW + 1)'(FIFO_DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;   // PC of the next response that will be kept
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [31:0]   inst_q, inst_d;
    logic [31:0]   reg_pc_q, reg_pc_d;

    logic          credit_ok, req_fire, fifo_push, fifo_pop, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [31:0]   target_pc;
    fetch_entry_t  push_entry, head_entry;

    assign target_pc  = word_align(branch_target);
    // Requests in flight plus buffered words may never exceed the buffer, so
    // every response has a guaranteed slot and memory needs no backpressure.
    assign credit_ok  = ({1'b0, inflight_q} + {1'b0, fifo_count}) < DEPTH_LIM;
    assign imem_req_valid = rst_n && !branch_hazard && credit_ok;
    assign imem_req_addr  = pc_q;
    assign req_fire   = imem_req_valid && imem_req_ready;
    assign fifo_push  = imem_resp_valid && !branch_hazard && (discard_q == '0);
    assign fifo_pop   = !branch_hazard && !stall_flg && !fifo_empty;
    assign push_entry = '{pc: resp_pc_q, inst: imem_resp_inst};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .flush     (branch_hazard),
        .head_data (head_entry),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    // PC, in-flight accounting and stale-response bookkeeping.
    always_comb begin
        pc_d       = pc_q;
        resp_pc_d  = resp_pc_q;
        inflight_d = inflight_q - CW'(imem_resp_valid) + CW'(req_fire);
        discard_d  = discard_q;
        if (branch_hazard) begin
            // Every outstanding response is stale; one arriving now is dropped
            // directly, so it is not counted again.
            pc_d      = target_pc;
            resp_pc_d = target_pc;
            discard_d = inflight_q - CW'(imem_resp_valid);
        end else begin
            if (req_fire) begin
                pc_d = pc_q + 32'd4;
            end
            if (imem_resp_valid) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - 1'b1;
                end else begin
                    resp_pc_d = resp_pc_q + 32'd4;
                end
            end
        end
    end

    // Decode-facing outputs: redirect forces a bubble, stall holds.
    always_comb begin
        inst_d   = inst_q;
        reg_pc_d = reg_pc_q;
        if (branch_hazard) begin
            inst_d   = INST_NOP;
            reg_pc_d = REGPC_NOP;
        end else if (!stall_flg) begin
            if (!fifo_empty) begin
                inst_d   = head_entry.inst;
                reg_pc_d = head_entry.pc;
            end else begin
                inst_d   = INST_NOP;
                reg_pc_d = REGPC_NOP;
            end
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
            inst_q     <= INST_NOP;
            reg_pc_q   <= REGPC_NOP;
        end else begin
            pc_q       <= pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            inst_q     <= inst_d;
            reg_pc_q   <= reg_pc_d;
        end
    end

    assign inst   = inst_q;
    assign reg_pc = reg_pc_q;

    credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
        ({1'b0, inflight_q} + {1'b0, fifo_count}) <= DEPTH_LIM);

endmodule
